// File: rtl/seq_pkg.sv
// Shared definitions for the 11001 detector and its downstream match logger.
// Holds default widths, the detected pattern and the detector state encodings.
package seq_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int CNT_W_DEF = 8;

    localparam int          PAT_LEN = 5;
    localparam logic [4:0]  PATTERN = 5'b11001;

    // Detector progress: Sn means the last n bits match the first n pattern bits.
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } det_state_t;

endpackage

// File: rtl/seq_event_fifo.sv
// Synchronous DEPTH x TS_W event FIFO with registered show-ahead head; push->head_vld 1 cycle.
// Backpressure: pop only when non-empty; push while full accepted only with a same-cycle pop.
module seq_event_fifo
    import seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [TS_W-1:0]          push_dat,
    input  logic                     pop,
    output logic                     full,
    output logic                     head_vld,
    output logic [TS_W-1:0]          head_dat,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

    logic [TS_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_nxt;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full     = (count == FULL_LVL);
    assign head_vld = (count != '0);
    assign level    = count;
    assign rd_nxt   = rd_ptr + AW'(1);

    assign do_pop  = pop & head_vld;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head_dat <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_nxt;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE_LVL;
                2'b01:   count <= count - ONE_LVL;
                default: count <= count;
            endcase
            // Head register tracks the entry that will be at rd_ptr next cycle;
            // when the FIFO drains empty it keeps the last delivered value.
            if (do_pop) begin
                if (count > ONE_LVL) begin
                    head_dat <= mem[rd_nxt];
                end else if (do_push) begin
                    head_dat <= push_dat;
                end
            end else if (do_push && count == '0) begin
                head_dat <= push_dat;
            end
        end
    end

endmodule

// File: rtl/seq_match_logger.sv
// Timestamps detector match pulses into an event FIFO, with saturating count and sticky overflow.
// Latency: match in cycle N -> ev_valid/ev_ts in N+1; ev_ready stalls the head, a match while full with no pop is dropped.
module seq_match_logger
    import seq_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = 4,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     match_in,
    input  logic                     clear_stats,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [TS_W-1:0]          ev_ts,
    output logic [CNT_W-1:0]         match_count,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [TS_W-1:0] ts_ctr;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;

    assign pop  = ev_valid & ev_ready;
    assign push = match_in & (~full | pop);
    assign drop = match_in & full & ~pop;

    seq_event_fifo #(
        .DEPTH (DEPTH),
        .TS_W  (TS_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (ts_ctr),
        .pop      (pop),
        .full     (full),
        .head_vld (ev_valid),
        .head_dat (ev_ts),
        .level    (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_ctr      <= '0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else begin
            ts_ctr <= ts_ctr + TS_W'(1);
            // A clear still counts and flags an event arriving in the same cycle.
            if (clear_stats) begin
                match_count <= match_in ? CNT_W'(1) : '0;
                overflow    <= drop;
            end else begin
                if (match_in && match_count != CNT_MAX) begin
                    match_count <= match_count + CNT_W'(1);
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_match_logger.sv
// Bench for seq_match_logger: directed scenarios plus random traffic against a queue-style model.
module tb_seq_match_logger;
    import seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic in_m [2];
    logic in_r [2];
    logic in_c [2];
    logic in_rst [2];

    logic        ev_valid_a, ovf_a;
    logic [15:0] ts_a;
    logic [7:0]  cnt_a;
    logic [2:0]  lvl_a;

    logic        ev_valid_b, ovf_b;
    logic [2:0]  ts_b;
    logic [1:0]  cnt_b;
    logic [2:0]  lvl_b;

    seq_match_logger #(.TS_W(16), .DEPTH(4), .CNT_W(8)) dut_a (
        .clk(clk), .reset(in_rst[0]), .match_in(in_m[0]), .clear_stats(in_c[0]),
        .ev_valid(ev_valid_a), .ev_ready(in_r[0]), .ev_ts(ts_a),
        .match_count(cnt_a), .overflow(ovf_a), .fifo_level(lvl_a)
    );

    seq_match_logger #(.TS_W(3), .DEPTH(4), .CNT_W(2)) dut_b (
        .clk(clk), .reset(in_rst[1]), .match_in(in_m[1]), .clear_stats(in_c[1]),
        .ev_valid(ev_valid_b), .ev_ready(in_r[1]), .ev_ts(ts_b),
        .match_count(cnt_b), .overflow(ovf_b), .fifo_level(lvl_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: an ordered list of pending timestamps per instance.
    int mq [2][8];
    int msz [2];
    int mts [2];
    int mcnt [2];
    int movf [2];
    int tsmod [2] = '{65536, 8};
    int cmax [2]  = '{255, 3};

    int got_a [$];
    int got_b [$];

    logic [4:0] win;
    int         nb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input int k);
        bit pop_e, drop_e;
        if (in_rst[k]) begin
            msz[k] = 0; mts[k] = 0; mcnt[k] = 0; movf[k] = 0;
            return;
        end
        pop_e  = (msz[k] > 0) && in_r[k];
        drop_e = in_m[k] && (msz[k] == 4) && !pop_e;
        if (pop_e) begin
            for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
            msz[k]--;
        end
        if (in_m[k] && !drop_e) begin
            mq[k][msz[k]] = mts[k];
            msz[k]++;
        end
        if (in_c[k]) begin
            mcnt[k] = in_m[k] ? 1 : 0;
            movf[k] = drop_e ? 1 : 0;
        end else begin
            if (in_m[k] && mcnt[k] < cmax[k]) mcnt[k]++;
            if (drop_e) movf[k] = 1;
        end
        mts[k] = (mts[k] + 1) % tsmod[k];
    endtask

    task automatic check_all();
        chk("a_valid", ev_valid_a, msz[0] > 0);
        chk("a_level", lvl_a, msz[0]);
        chk("a_count", cnt_a, mcnt[0]);
        chk("a_overflow", ovf_a, movf[0]);
        if (msz[0] > 0) chk("a_ts", ts_a, mq[0][0]);
        chk("b_valid", ev_valid_b, msz[1] > 0);
        chk("b_level", lvl_b, msz[1]);
        chk("b_count", cnt_b, mcnt[1]);
        chk("b_overflow", ovf_b, movf[1]);
        if (msz[1] > 0) chk("b_ts", ts_b, mq[1][0]);
    endtask

    task automatic tick();
        if (!in_rst[0] && in_r[0] && ev_valid_a) got_a.push_back(int'(ts_a));
        if (!in_rst[1] && in_r[1] && ev_valid_b) got_b.push_back(int'(ts_b));
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        check_all();
    endtask

    task automatic do_reset(input int k);
        in_rst[k] = 1'b1;
        tick();
        in_rst[k] = 1'b0;
        if (k == 0) begin
            nb  = 0;
            win = '0;
        end
    endtask

    // Detector behaviour at the level of the bit stream: a match when the last five bits are 11001.
    task automatic din_bit(input logic b);
        win = {win[3:0], b};
        nb++;
        in_m[0] = (nb >= PAT_LEN) && (win == PATTERN);
        tick();
        in_m[0] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            in_m[k] = 1'b0; in_r[k] = 1'b0; in_c[k] = 1'b0; in_rst[k] = 1'b1;
        end
        win = '0;
        nb  = 0;
        #2;
        tick();
        tick();
        chk("rst_valid", ev_valid_a, 0);
        chk("rst_ts", ts_a, 0);
        chk("rst_level", lvl_a, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_overflow", ovf_a, 0);
        in_rst[0] = 1'b0;
        in_rst[1] = 1'b0;

        // 1: single 11001 with bits at ts 0..4
        din_bit(1'b1); din_bit(1'b1); din_bit(1'b0); din_bit(1'b0); din_bit(1'b1);
        chk("t1_valid", ev_valid_a, 1);
        chk("t1_ts", ts_a, 4);
        chk("t1_count", cnt_a, 1);

        // 2: matches at ts 4 and 7, consumer always ready
        do_reset(0);
        in_r[0] = 1'b1;
        got_a.delete();
        for (int t = 0; t <= 8; t++) begin
            in_m[0] = (t == 4 || t == 7);
            tick();
        end
        in_m[0] = 1'b0;
        in_r[0] = 1'b0;
        chk("t2_delivered", got_a.size(), 2);
        if (got_a.size() == 2) begin
            chk("t2_first", got_a[0], 4);
            chk("t2_second", got_a[1], 7);
        end
        chk("t2_count", cnt_a, 2);
        chk("t2_overflow", ovf_a, 0);

        // 3: five matches with no consumer, then drain
        do_reset(0);
        got_a.delete();
        for (int i = 0; i < 5; i++) begin
            in_m[0] = 1'b1; tick();
            in_m[0] = 1'b0; tick();
        end
        chk("t3_level", lvl_a, 4);
        chk("t3_overflow", ovf_a, 1);
        chk("t3_count", cnt_a, 5);
        in_r[0] = 1'b1;
        repeat (6) tick();
        in_r[0] = 1'b0;
        chk("t3_delivered", got_a.size(), 4);
        for (int i = 0; i < 4 && i < got_a.size(); i++) chk("t3_order", got_a[i], 2 * i);

        // 4: full FIFO, push and pop in the same cycle
        do_reset(0);
        in_m[0] = 1'b1;
        repeat (4) tick();
        chk("t4_full", lvl_a, 4);
        got_a.delete();
        in_r[0] = 1'b1;
        tick();
        in_m[0] = 1'b0;
        chk("t4_level_held", lvl_a, 4);
        chk("t4_overflow", ovf_a, 0);
        repeat (5) tick();
        in_r[0] = 1'b0;
        chk("t4_delivered", got_a.size(), 5);
        for (int i = 0; i < 5 && i < got_a.size(); i++) chk("t4_order", got_a[i], i);

        // 5: clear_stats coinciding with a match
        do_reset(0);
        in_m[0] = 1'b1;
        repeat (5) tick();
        in_m[0] = 1'b0;
        chk("t5_pre_overflow", ovf_a, 1);
        in_r[0] = 1'b1;
        tick();
        in_r[0] = 1'b0;
        in_c[0] = 1'b1;
        in_m[0] = 1'b1;
        tick();
        in_c[0] = 1'b0;
        in_m[0] = 1'b0;
        chk("t5_count", cnt_a, 1);
        chk("t5_overflow", ovf_a, 0);
        chk("t5_level", lvl_a, 4);
        chk("t5_head", ts_a, 1);

        // 6: narrow instance - saturation and timestamp wrap
        do_reset(1);
        in_m[1] = 1'b1;
        repeat (5) tick();
        in_m[1] = 1'b0;
        chk("t6_saturate", cnt_b, 3);
        do_reset(1);
        got_b.delete();
        repeat (7) tick();
        in_m[1] = 1'b1;
        tick();
        tick();
        in_m[1] = 1'b0;
        in_r[1] = 1'b1;
        repeat (3) tick();
        in_r[1] = 1'b0;
        chk("t6_delivered", got_b.size(), 2);
        if (got_b.size() == 2) begin
            chk("t6_ts_before_wrap", got_b[0], 7);
            chk("t6_ts_after_wrap", got_b[1], 0);
        end

        // Reset with events queued
        do_reset(0);
        in_m[0] = 1'b1;
        repeat (3) tick();
        in_m[0] = 1'b0;
        chk("rst_mid_level_before", lvl_a, 3);
        in_rst[0] = 1'b1;
        tick();
        in_rst[0] = 1'b0;
        nb = 0;
        chk("rst_mid_valid", ev_valid_a, 0);
        chk("rst_mid_level", lvl_a, 0);

        // Random traffic on both instances
        for (int n = 0; n < 400; n++) begin
            win = {win[3:0], logic'($urandom_range(0, 99) < 60)};
            nb++;
            in_m[0] = (nb >= PAT_LEN) && (win == PATTERN);
            in_r[0] = ($urandom_range(0, 99) < 35);
            in_c[0] = ($urandom_range(0, 99) < 3);
            in_m[1] = ($urandom_range(0, 99) < 40);
            in_r[1] = ($urandom_range(0, 99) < 30);
            in_c[1] = ($urandom_range(0, 99) < 3);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
